// File: rtl/seq_restoring_divider_pkg.sv
// div_pkg: shared FSM state type and default widths for the restoring divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CW_DEF = $clog2(DW_DEF);
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/busy/done handshake and operand/result bus.
interface seq_restoring_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// div_step: one restoring-division step, shifting in a dividend bit and trial-subtracting the divisor.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] rem,
    input  logic          din,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_nx,
    output logic          q_bit
);
    // One extra bit so the shifted partial never overflows before the compare
    logic [VW:0] partial, diff;
    always_comb begin
        partial = {rem, din};
        diff    = partial - {1'b0, divisor};
        q_bit   = partial >= {1'b0, divisor};
        rem_nx  = q_bit ? diff[VW-1:0] : partial[VW-1:0];
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider producing one quotient bit per clock.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input logic                   clk,
    input logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(DW);
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd, quo;
    logic [VW-1:0] dvs, rem, rem_nx;
    logic          q_bit, dbz, accept, zero_div;
    assign accept   = bus.start && state != RUN;
    assign zero_div = bus.divisor == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = IDLE;
        if (accept)            state_nx = zero_div ? DONE : RUN;
        else if (state == RUN) state_nx = cnt == '0 ? DONE : RUN;
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end
    // A zero divisor skips iteration and reports the all-ones quotient directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dvd <= '0;
            dvs <= '0;
            quo <= '0;
            rem <= '0;
            dbz <= 1'b0;
        end else if (accept) begin
            cnt <= CW'(DW - 1);
            dvd <= bus.dividend;
            dvs <= bus.divisor;
            quo <= {DW{zero_div}};
            rem <= '0;
            dbz <= zero_div;
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            dvd <= {dvd[DW-2:0], 1'b0};
            quo <= {quo[DW-2:0], q_bit};
            rem <= rem_nx;
        end
    end
    div_step #(.VW(VW)) u_step (
        .rem     (rem),
        .din     (dvd[DW-1]),
        .divisor (dvs),
        .rem_nx  (rem_nx),
        .q_bit   (q_bit)
    );
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and random checks of the divider against plain / and % arithmetic.
module tb_seq_restoring_divider;
    localparam int DW = 8;
    localparam int VW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    seq_restoring_divider_if #(.DW(DW), .VW(VW)) bus ();
    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input bit hold, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        do begin
            tick();
            lat++;
            if (bus.busy === 1'b1) bc++;
            if (!hold) bus.start = 1'b0;
        end while (bus.done !== 1'b1 && lat < 20);
    endtask
    task automatic expect_result(input string tag, input int a, input int b, input int lat, input int bc);
        int eq, er, ez, el, eb;
        if (b == 0) begin
            eq = 255; er = 0; ez = 1; el = 1; eb = 0;
        end else begin
            eq = a / b; er = a % b; ez = 0; el = 9; eb = 8;
        end
        check({tag, " latency"}, lat, el);
        check({tag, " busy_cycles"}, bc, eb);
        check({tag, " done"}, {31'd0, bus.done}, 1);
        check({tag, " quotient"}, {24'd0, bus.quotient}, eq);
        check({tag, " remainder"}, {28'd0, bus.remainder}, er);
        check({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, ez);
    endtask
    task automatic op(input string tag, input int a, input int b);
        int lat, bc;
        bus.start    = 1'b1;
        bus.dividend = DW'(a);
        bus.divisor  = VW'(b);
        wait_done(1'b0, lat, bc);
        expect_result(tag, a, b, lat, bc);
    endtask
    task automatic op_idle(input string tag, input int a, input int b);
        op(tag, a, b);
        tick();
        check({tag, " done_pulse_end"}, {31'd0, bus.done}, 0);
    endtask
    initial begin
        int lat, bc, a, b, seen;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check("reset busy", {31'd0, bus.busy}, 0);
        check("reset done", {31'd0, bus.done}, 0);
        check("reset quotient", {24'd0, bus.quotient}, 0);
        check("reset remainder", {28'd0, bus.remainder}, 0);
        check("reset dbz", {31'd0, bus.div_by_zero}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        op_idle("basic 200/7", 200, 7);
        op_idle("255/15", 255, 15);
        op_idle("255/1", 255, 1);
        op_idle("5/9", 5, 9);
        op_idle("0/3", 0, 3);
        op_idle("div0 13/0", 13, 0);
        op_idle("after div0 10/3", 10, 3);
        // start held high: operands disturbed mid-run, restored before the accepting done cycle
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd9;
        lat = 0;
        bc  = 0;
        do begin
            tick();
            lat++;
            if (bus.busy === 1'b1) bc++;
            if (lat == 4) begin bus.dividend = 8'd50; bus.divisor = 4'd3; end
            if (lat == 6) begin bus.dividend = 8'd100; bus.divisor = 4'd9; end
        end while (bus.done !== 1'b1 && lat < 20);
        expect_result("held start #1", 100, 9, lat, bc);
        wait_done(1'b1, lat, bc);
        expect_result("held start #2", 100, 9, lat, bc);
        bus.start = 1'b0;
        tick();
        check("held start idle done", {31'd0, bus.done}, 0);
        check("held start idle busy", {31'd0, bus.busy}, 0);
        // back-to-back: new op accepted in the done cycle
        op("b2b first 200/7", 200, 7);
        bus.start    = 1'b1;
        bus.dividend = 8'd77;
        bus.divisor  = 4'd5;
        check("b2b held quotient", {24'd0, bus.quotient}, 28);
        check("b2b held remainder", {28'd0, bus.remainder}, 4);
        tick();
        bus.start = 1'b0;
        check("b2b accepted busy", {31'd0, bus.busy}, 1);
        wait_done(1'b0, lat, bc);
        expect_result("b2b 77/5", 77, 5, lat + 1, bc + 1);
        tick();
        // reset during iteration
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("pre-reset busy", {31'd0, bus.busy}, 1);
        #1 rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, bus.busy}, 0);
        check("async rst done", {31'd0, bus.done}, 0);
        check("async rst quotient", {24'd0, bus.quotient}, 0);
        check("async rst remainder", {28'd0, bus.remainder}, 0);
        check("async rst dbz", {31'd0, bus.div_by_zero}, 0);
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        check("no stray activity after reset", seen, 0);
        op_idle("post-reset 200/7", 200, 7);
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) op_idle($sformatf("rand%0d %0d/%0d", i, a, b), a, b);
            else op($sformatf("rand%0d %0d/%0d", i, a, b), a, b);
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential unsigned restoring divider, the inverse operation of the team's 4x4 array multiplier: takes an 8-bit product-sized dividend and a 4-bit divisor, returns quotient and remainder.
- Produces one quotient bit per clock. Uses a start/busy/done handshake so the tile top can drive it from ui_in and a registered control bit.
- Sits beside the multiplier in the tile. Together they give multiply/divide round-trip checks.

Parameters:
- DW, 8, dividend and quotient width (bits).
- VW, 4, divisor and remainder width (bits); VW < DW required.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when state is IDLE or DONE.
- dividend  input  DW  unsigned dividend, captured on accepted start.
- divisor  input  VW  unsigned divisor, captured on accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle.
- quotient  output  DW  result, held until next accepted start.
- remainder  output  VW  result, held until next accepted start.
- div_by_zero  output  1  set with done when captured divisor == 0; held with results.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter/registers=0. In-flight operation is discarded, and no done is issued for it.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> capture operands and clear quotient/remainder/div_by_zero. Go to RUN, or to DONE if divisor==0.
- RUN: busy=1. Counter starts at DW-1 and decrements each cycle. Each step:
  - partial = {rem, next dividend bit, MSB first} (VW+1 bits).
  - If partial >= divisor: rem = partial - divisor, quotient bit = 1.
  - Else: rem = partial[VW-1:0], quotient bit = 0.
  - After the step with counter==0, go to DONE. Start is ignored in RUN.
- DONE: done=1 for exactly one cycle, busy=0, results stable.
  - start=1 in DONE is accepted, same as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start high in cycle 0 (sampled at the end-of-cycle edge). Busy is high in cycles 1..DW and done in cycle DW+1, so 9 cycles for defaults.
- Divide by zero: done in cycle 1, busy never asserts. quotient = all ones (0xFF), remainder = 0, div_by_zero = 1.
- Outputs quotient/remainder are registered. They may show partial values while busy=1; they are valid only at done and thereafter until the next accepted start.
- Arithmetic is unsigned only. The remainder is always < divisor, so VW bits suffice. The internal partial remainder is VW+1 bits to avoid overflow on compare.

Decomposition:
- Shared package (div_pkg): state enum (IDLE, RUN, DONE), default widths DW=8/VW=4, counter width $clog2(DW).
- One combinational sub-module, div_step. Inputs: rem (VW), next dividend bit, divisor (VW). Outputs: new rem (VW) and quotient bit.
- The top holds the FSM, counter, operand shift register and output registers.

Test Plan:
- Basic: dividend=200, divisor=7, start pulse cycle 0 -> busy cycles 1–8, done cycle 9, quotient=28, remainder=4, div_by_zero=0.
- Extremes: 255/15 -> q=17, r=0. 255/1 -> q=255, r=0. 5/9 -> q=0, r=5. 0/3 -> q=0, r=0. Each has done exactly 9 cycles after start.
- Divide by zero: 13/0 -> done in cycle 1, busy never high, q=0xFF, r=0, div_by_zero=1. The next valid op, 10/3, clears div_by_zero and gives q=3, r=1.
- Handshake: start held high continuously with 100/9 -> start ignored while busy. Done pulses every 9 cycles with q=11, r=1. Operand change mid-RUN has no effect on the result.
- Back-to-back: start asserted in the DONE cycle with 77/5 -> new op accepted, no IDLE cycle. Done 9 cycles later with q=15, r=2. The previous results are held until that accept.
- Reset mid-operation: assert rst in cycle 4 of 200/7 -> busy/done/outputs 0 immediately (async). No stray done afterward, and a fresh 200/7 gives q=28, r=4.
